crc16_frame_checker: RTL and testbench
======================================

CRC16_FRAME_CHECKER -- requirements
Module: crc16_frame_checker

Interface
REQ-001 Parameter INIT, default 16'hFFFF, CRC register value at frame start.
REQ-002 Parameter OUTPUT_XOR, default 16'h0000, XOR applied to the final computed CRC before compare.
REQ-003 Parameter INPUT_INV, default 1'b0, bit-reverses each byte before CRC update when 1.
REQ-004 Parameter OUTPUT_INV, default 1'b0, bit-reverses the 16-bit CRC before OUTPUT_XOR when 1.
REQ-005 Parameter CRC_MSB_FIRST, default 1'b1; 1: first received CRC byte is crc[15:8]; 0: first is crc[7:0].
REQ-006 One clock; reset is synchronous and active-high: clk  input  1  rising-edge clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 s_data/s_valid/s_last/s_ready  in/in/in/out  8/1/1/1  byte stream of payload followed by 2 CRC bytes; s_last marks the final CRC byte.
REQ-009 m_data/m_valid/m_last/m_ready  out/out/out/in  8/1/1/1  payload stream with the CRC bytes stripped.
REQ-010 status_valid/status_ok/status_runt  out  1/1/1  one-cycle per-frame result.
REQ-011 crc_calc/crc_rx  out  16/16  computed (post inv/xor) and received CRC, held from status_valid until the next status_valid.
REQ-012 frame_cnt/err_cnt  out  16/16  frames completed / frames failed, saturating.

Function
REQ-013 Polynomial SHALL be fixed x^16+x^12+x^5+1 (0x1021), byte-parallel, MSB-first shift.
REQ-014 Transfers SHALL occur only when valid and ready are both high; s_ready = (state!=STATUS) && (!m_valid || m_ready).
REQ-015 A 2-byte holding buffer SHALL delay input; on acceptance of byte n with 2 bytes buffered, byte n-2 SHALL be registered to m_data (m_valid=1 next cycle) and folded into the CRC register.
REQ-016 Latency: payload byte k SHALL appear on m_data the cycle after byte k+2 is accepted.
REQ-017 On s_last acceptance with a full buffer, the emitted byte SHALL carry m_last=1; the buffered byte plus the s_last byte SHALL form crc_rx per CRC_MSB_FIRST.
REQ-018 States: IDLE (buffer 0), FILL (buffer 1..2), STATUS; IDLE->FILL on accept; FILL->STATUS on s_last accept; STATUS->IDLE unconditionally after one cycle.
REQ-019 In STATUS: status_valid=1, status_ok=(crc_calc==crc_rx)&&!runt, CRC register reloaded to INIT, buffer cleared.
REQ-020 Frames of 1 or 2 bytes (s_last before buffer full) SHALL give status_runt=1, status_ok=0, no m output.
REQ-021 frame_cnt SHALL increment on every status_valid; err_cnt on every status_valid with status_ok=0; both saturate at 16'hFFFF.
REQ-022 m_valid SHALL hold with m_data/m_last stable until m_ready; input stalls meanwhile.

Reset
REQ-023 rst SHALL force: state IDLE, buffer empty, CRC register INIT, m_valid=0, m_last=0, m_data=0, status_valid/ok/runt=0, crc_calc=crc_rx=0, counters 0.
REQ-024 rst mid-frame SHALL discard the partial frame with no status pulse and no counter change.

Structure
REQ-025 Package crc16_pkg SHALL hold the polynomial constant, state encoding, and CRC width constant.
REQ-026 Sub-module crc16_byte_update (combinational: 16-bit state + 8-bit data -> next state) SHALL be instantiated once.

Verification
REQ-027 Defaults, frame "123456789" + 8'h29, 8'hB1 -> 9 bytes out, m_last on 8'h39, status_ok=1, crc_calc=16'h29B1, frame_cnt=1.
REQ-028 Same frame with last byte 8'hB0 -> status_ok=0, crc_rx=16'h29B0, err_cnt=1, payload still delivered.
REQ-029 Frame 8'h00, 8'hE1, 8'hF0 -> one output byte with m_last=1, status_ok=1, crc_calc=16'hE1F0.
REQ-030 Two-byte frame 8'hAA, 8'hBB(last) -> status_runt=1, status_ok=0, no m_valid, err_cnt+1.
REQ-031 REQ-027 frame with m_ready toggling 1-of-3 cycles -> identical output bytes and status, no byte lost or duplicated.
REQ-032 rst asserted after 5 bytes of a frame, then REQ-027 frame -> only one status_valid, status_ok=1, frame_cnt=1.

Source files
------------

// File: rtl/crc16_pkg.sv
// Shared constants and helpers for the CRC-16 frame checker.
// Holds the CRC width, the fixed 0x1021 polynomial, the checker FSM state
// encoding and bit-reversal helpers used for the input/output inversion options.
package crc16_pkg;

    localparam int unsigned CrcW    = 16;
    localparam logic [15:0] CrcPoly = 16'h1021;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StStatus
    } state_e;

    function automatic logic [7:0] rev8(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = d[7-i];
        end
        return r;
    endfunction

    function automatic logic [15:0] rev16(input logic [15:0] d);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) begin
            r[i] = d[15-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc16_byte_update.sv
// Byte-parallel CRC-16 update, polynomial 0x1021, MSB-first shift.
// Ports:
//   crc_i  - current CRC register value
//   data_i - byte to fold in
//   crc_o  - CRC register value after the byte
module crc16_byte_update
    import crc16_pkg::*;
(
    input  logic [CrcW-1:0] crc_i,
    input  logic [7:0]      data_i,
    output logic [CrcW-1:0] crc_o
);

    logic [CrcW-1:0] c;

    always_comb begin
        c = crc_i ^ {data_i, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CrcPoly) : (c << 1);
        end
        crc_o = c;
    end

endmodule

// File: rtl/crc16_frame_checker.sv
// Streaming CRC-16 frame checker. Each input frame is payload followed by two
// CRC bytes; the payload is forwarded with the CRC bytes stripped, and a
// one-cycle status pulse reports whether the received CRC matched.
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   s_data/s_valid/s_last/s_ready     - input byte stream (s_last on final CRC byte)
//   m_data/m_valid/m_last/m_ready     - payload output stream
//   status_valid/status_ok/status_runt- per-frame result pulse
//   crc_calc/crc_rx                   - computed and received CRC of the last frame
//   frame_cnt/err_cnt                 - saturating frame / error counters
module crc16_frame_checker
    import crc16_pkg::*;
#(
    parameter logic [15:0] INIT          = 16'hFFFF,
    parameter logic [15:0] OUTPUT_XOR    = 16'h0000,
    parameter bit          INPUT_INV     = 1'b0,
    parameter bit          OUTPUT_INV    = 1'b0,
    parameter bit          CRC_MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready,
    output logic        status_valid,
    output logic        status_ok,
    output logic        status_runt,
    output logic [15:0] crc_calc,
    output logic [15:0] crc_rx,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
);

    state_e state_q, state_d;

    logic [7:0]      buf0_q, buf0_d;   // older buffered byte
    logic [7:0]      buf1_q, buf1_d;   // newer buffered byte
    logic [1:0]      cnt_q, cnt_d;
    logic [CrcW-1:0] crc_q, crc_d;
    logic [7:0]      m_data_q, m_data_d;
    logic            m_valid_q, m_valid_d;
    logic            m_last_q, m_last_d;
    logic            runt_q, runt_d;
    logic [15:0]     crc_calc_q, crc_calc_d;
    logic [15:0]     crc_rx_q, crc_rx_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic [15:0]     err_cnt_q, err_cnt_d;

    logic            accept;
    logic [7:0]      fold_byte;
    logic [CrcW-1:0] crc_upd;

    function automatic logic [15:0] finalize(input logic [15:0] c);
        return (OUTPUT_INV ? rev16(c) : c) ^ OUTPUT_XOR;
    endfunction

    assign fold_byte = INPUT_INV ? rev8(buf0_q) : buf0_q;

    crc16_byte_update u_update (
        .crc_i  (crc_q),
        .data_i (fold_byte),
        .crc_o  (crc_upd)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = s_last ? StStatus : StFill;
            StFill:   if (accept && s_last) state_d = StStatus;
            StStatus: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        s_ready      = (state_q != StStatus) && (!m_valid_q || m_ready);
        accept       = s_valid && s_ready;
        status_valid = (state_q == StStatus);
        status_ok    = status_valid && (crc_calc_q == crc_rx_q) && !runt_q;
        status_runt  = status_valid && runt_q;
    end

    // Datapath next state
    always_comb begin
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;
        cnt_d       = cnt_q;
        crc_d       = crc_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        runt_d      = runt_q;
        crc_calc_d  = crc_calc_q;
        crc_rx_d    = crc_rx_q;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end

        if (accept) begin
            buf0_d = buf1_q;
            buf1_d = s_data;
            if (cnt_q != 2'd2) cnt_d = cnt_q + 2'd1;
            // With two bytes held, the oldest is known to be payload.
            if (cnt_q == 2'd2) begin
                m_data_d  = buf0_q;
                m_valid_d = 1'b1;
                m_last_d  = s_last;
                crc_d     = crc_upd;
            end
            // Results land in the same cycle status_valid rises.
            if (s_last) begin
                runt_d     = (cnt_q != 2'd2);
                crc_calc_d = finalize((cnt_q == 2'd2) ? crc_upd : crc_q);
                crc_rx_d   = CRC_MSB_FIRST ? {buf1_q, s_data} : {s_data, buf1_q};
            end
        end

        if (state_q == StStatus) begin
            crc_d  = INIT;
            buf0_d = 8'h00;
            buf1_d = 8'h00;
            cnt_d  = 2'd0;
            if (frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
            if (!status_ok && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf0_q      <= 8'h00;
            buf1_q      <= 8'h00;
            cnt_q       <= 2'd0;
            crc_q       <= INIT;
            m_data_q    <= 8'h00;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            runt_q      <= 1'b0;
            crc_calc_q  <= 16'h0000;
            crc_rx_q    <= 16'h0000;
            frame_cnt_q <= 16'h0000;
            err_cnt_q   <= 16'h0000;
        end else begin
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            cnt_q       <= cnt_d;
            crc_q       <= crc_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            runt_q      <= runt_d;
            crc_calc_q  <= crc_calc_d;
            crc_rx_q    <= crc_rx_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;
    assign crc_calc  = crc_calc_q;
    assign crc_rx    = crc_rx_q;
    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_crc16_frame_checker.sv
// Scoreboard bench for crc16_frame_checker: the driver pushes expected payload
// bytes and status results into queues, a monitor pops and compares them.
module tb_crc16_frame_checker;

    typedef logic [7:0] frame_t [16];

    typedef struct {
        logic        ok;
        logic        runt;
        logic        chk_crc;
        logic [15:0] calc;
        logic [15:0] rx;
        logic [15:0] fcnt;
        logic [15:0] ecnt;
    } st_t;

    logic        clk;
    logic        rst;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready;
    logic        status_valid;
    logic        status_ok;
    logic        status_runt;
    logic [15:0] crc_calc;
    logic [15:0] crc_rx;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;

    crc16_frame_checker dut (
        .clk          (clk),
        .rst          (rst),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_last       (m_last),
        .m_ready      (m_ready),
        .status_valid (status_valid),
        .status_ok    (status_ok),
        .status_runt  (status_runt),
        .crc_calc     (crc_calc),
        .crc_rx       (crc_rx),
        .frame_cnt    (frame_cnt),
        .err_cnt      (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    logic [8:0] exp_m[$];
    st_t        exp_s[$];
    int   exp_f = 0;
    int   exp_e = 0;
    bit   throttle = 1'b0;
    int   cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic note_fail(input string name);
        n_checks++;
        $display("FAIL %s: event occurred, none expected", name);
    endtask

    // m_ready changes just after the rising edge, so it is stable at the
    // falling edge where both driver and monitor sample.
    always @(posedge clk) begin
        #1;
        m_ready = throttle ? ((cyc % 3) == 0) : 1'b1;
        cyc++;
    end

    // Monitor
    bit         pend = 1'b0;
    st_t        pend_exp;
    bit         prev_stall = 1'b0;
    logic [8:0] prev_ml;

    always @(negedge clk) begin
        if (rst) begin
            pend       = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (pend) begin
                chk("frame_cnt", frame_cnt, pend_exp.fcnt);
                chk("err_cnt", err_cnt, pend_exp.ecnt);
                pend = 1'b0;
            end
            if (prev_stall) chk("m_hold", {m_valid, m_last, m_data}, {1'b1, prev_ml});
            prev_stall = m_valid && !m_ready;
            prev_ml    = {m_last, m_data};
            if (m_valid && m_ready) begin
                if (exp_m.size() == 0) note_fail("m_unexpected");
                else chk("m_byte", {m_last, m_data}, exp_m.pop_front());
            end
            if (status_valid) begin
                if (exp_s.size() == 0) begin
                    note_fail("status_unexpected");
                end else begin
                    pend_exp = exp_s.pop_front();
                    chk("status_ok", status_ok, pend_exp.ok);
                    chk("status_runt", status_runt, pend_exp.runt);
                    if (pend_exp.chk_crc) begin
                        chk("crc_calc", crc_calc, pend_exp.calc);
                        chk("crc_rx", crc_rx, pend_exp.rx);
                    end
                    pend = 1'b1;
                end
            end
        end
    end

    task automatic push_status(input logic ok, input logic runt, input logic chk_crc,
                               input logic [15:0] calc, input logic [15:0] rx);
        st_t e;
        exp_f++;
        if (!ok) exp_e++;
        e.ok      = ok;
        e.runt    = runt;
        e.chk_crc = chk_crc;
        e.calc    = calc;
        e.rx      = rx;
        e.fcnt    = 16'(exp_f);
        e.ecnt    = 16'(exp_e);
        exp_s.push_back(e);
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_byte(input logic [7:0] d, input logic last);
        int w = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!s_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!s_ready) note_fail("s_ready_timeout");
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input frame_t b, input int n, input bit with_last);
        for (int i = 0; i < n; i++) begin
            if (i >= 2) exp_m.push_back({with_last && (i == n - 1), b[i-2]});
            send_byte(b[i], with_last && (i == n - 1));
        end
    endtask

    task automatic drain();
        int w = 0;
        while ((exp_m.size() != 0 || exp_s.size() != 0 || pend) && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("drain", {exp_m.size() == 0, exp_s.size() == 0}, 2'b11);
        repeat (2) @(negedge clk);
    endtask

    frame_t f_good, f_bad, f_short, f_runt, f_one;

    initial begin
        f_good  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                    8'h29, 8'hB1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        f_bad   = f_good;
        f_bad[10] = 8'hB0;
        f_short = '{default: 8'h00};
        f_short[1] = 8'hE1;
        f_short[2] = 8'hF0;
        f_runt  = '{default: 8'h00};
        f_runt[0] = 8'hAA;
        f_runt[1] = 8'hBB;
        f_one   = '{default: 8'h00};
        f_one[0] = 8'h55;

        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_m", {m_valid, m_last, m_data}, 10'h000);
        chk("rst_status", {status_valid, status_ok, status_runt}, 3'b000);
        chk("rst_crc", {crc_calc, crc_rx}, 32'h0);
        chk("rst_cnt", {frame_cnt, err_cnt}, 32'h0);
        chk("rst_s_ready", s_ready, 1'b1);

        // Good check-string frame
        push_status(1'b1, 1'b0, 1'b1, 16'h29B1, 16'h29B1);
        send_frame(f_good, 11, 1'b1);
        drain();

        // Corrupted final CRC byte
        push_status(1'b0, 1'b0, 1'b1, 16'h29B1, 16'h29B0);
        send_frame(f_bad, 11, 1'b1);
        drain();

        // Minimal frame: one payload byte
        push_status(1'b1, 1'b0, 1'b1, 16'hE1F0, 16'hE1F0);
        send_frame(f_short, 3, 1'b1);
        drain();

        // Runt frames of two and one bytes
        push_status(1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
        send_frame(f_runt, 2, 1'b1);
        drain();
        push_status(1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
        send_frame(f_one, 1, 1'b1);
        drain();

        // Output backpressure
        throttle = 1'b1;
        push_status(1'b1, 1'b0, 1'b1, 16'h29B1, 16'h29B1);
        send_frame(f_good, 11, 1'b1);
        drain();
        throttle = 1'b0;
        repeat (3) @(negedge clk);

        // Reset mid-frame, then a clean frame
        send_frame(f_good, 5, 1'b0);
        drain();
        rst = 1'b1;
        exp_f = 0;
        exp_e = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("midrst_cnt", {frame_cnt, err_cnt}, 32'h0);
        chk("midrst_m", {m_valid, status_valid}, 2'b00);
        push_status(1'b1, 1'b0, 1'b1, 16'h29B1, 16'h29B1);
        send_frame(f_good, 11, 1'b1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
